// File: rtl/route_if.sv
// route_if: command, station-ID, motion and queue-status signals of the route processor.
interface route_if #(
  parameter int ID_W  = 6,
  parameter int DEPTH = 4
);
  logic                       cmd_rdy, ID_vld, Ok2Move;
  logic [ID_W+1:0]            cmd, ID;
  logic                       clr_cmd_rdy, clr_ID_vld;
  logic                       go, in_transit, buzz, buzz_n;
  logic [ID_W-1:0]            dest_ID;
  logic [$clog2(DEPTH+1)-1:0] q_count;
  logic                       q_full, arrived, err_ovf;
  modport master (
    output cmd_rdy, cmd, ID_vld, ID, Ok2Move,
    input  clr_cmd_rdy, clr_ID_vld, go, in_transit, buzz, buzz_n,
    input  dest_ID, q_count, q_full, arrived, err_ovf
  );
  modport slave (
    input  cmd_rdy, cmd, ID_vld, ID, Ok2Move,
    output clr_cmd_rdy, clr_ID_vld, go, in_transit, buzz, buzz_n,
    output dest_ID, q_count, q_full, arrived, err_ovf
  );
endinterface

// File: rtl/route_proc.sv
// route_proc: destination queue with IDLE/TRANSIT motion control, arrival detection and piezo buzz.
module route_proc #(
  parameter int ID_W     = 6,
  parameter int DEPTH    = 4,
  parameter int BUZZ_DIV = 12500
) (
  input logic clk,
  input logic rst,
  route_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int QW = $clog2(DEPTH+1);
  localparam int CW = BUZZ_DIV > 1 ? $clog2(BUZZ_DIV) : 1;
  typedef enum logic {IDLE, TRANSIT} state_t;
  state_t state, state_nxt;
  logic [ID_W-1:0] mem [DEPTH];
  logic [AW-1:0]   rp, wp;
  logic [QW-1:0]   cnt, cnt_nxt;
  logic [CW-1:0]   bcnt;
  logic [ID_W-1:0] head;
  logic [1:0]      op;
  logic            buzz_q, arr_q, ovf_q;
  logic            is_stop, is_go, is_add, is_flush, full, pop, push, drop, leave, buzz_en;
  assign op       = bus.cmd[ID_W+1:ID_W];
  assign is_stop  = bus.cmd_rdy && op == 2'b00;
  assign is_go    = bus.cmd_rdy && op == 2'b01;
  assign is_add   = bus.cmd_rdy && op == 2'b10;
  assign is_flush = bus.cmd_rdy && op == 2'b11;
  assign full     = cnt == QW'(DEPTH);
  assign head     = cnt == '0 ? '0 : mem[rp];
  // FLUSH overrides an arrival in the same cycle, so it suppresses the pop
  assign pop      = state == TRANSIT && bus.ID_vld && bus.ID[ID_W+1:ID_W] == 2'b00 &&
                    bus.ID[ID_W-1:0] == head && cnt != '0 && !is_flush;
  assign push     = (is_go || is_add) && (!full || pop);
  assign drop     = (is_go || is_add) && full && !pop;
  assign cnt_nxt  = is_flush ? '0 : cnt + QW'(push) - QW'(pop);
  assign leave    = is_stop || is_flush || (pop && cnt == QW'(1) && !(is_go && push));
  assign buzz_en  = state == TRANSIT && !bus.Ok2Move;
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nxt;
  always_comb
    state_nxt = state == IDLE ? ((is_go && cnt_nxt != '0) ? TRANSIT : IDLE)
                              : (leave ? IDLE : TRANSIT);
  always_comb begin
    bus.clr_cmd_rdy = bus.cmd_rdy;
    bus.clr_ID_vld  = bus.ID_vld;
    bus.in_transit  = state == TRANSIT;
    bus.go          = state == TRANSIT && bus.Ok2Move;
    bus.buzz        = buzz_q;
    bus.buzz_n      = buzz_en ? ~buzz_q : 1'b0;
    bus.dest_ID     = head;
    bus.q_count     = cnt;
    bus.q_full      = full;
    bus.arrived     = arr_q;
    bus.err_ovf     = ovf_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rp    <= '0;
      wp    <= '0;
      cnt   <= '0;
      arr_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      if (push) mem[wp] <= bus.cmd[ID_W-1:0];
      wp    <= is_flush ? '0 : wp + AW'(push);
      rp    <= is_flush ? '0 : rp + AW'(pop);
      cnt   <= cnt_nxt;
      arr_q <= pop;
      ovf_q <= drop;
    end
  end
  always_ff @(posedge clk) begin
    if (rst || !buzz_en) begin
      bcnt   <= '0;
      buzz_q <= 1'b0;
    end else if (bcnt == CW'(BUZZ_DIV-1)) begin
      bcnt   <= '0;
      buzz_q <= ~buzz_q;
    end else begin
      bcnt   <= bcnt + CW'(1);
    end
  end
endmodule
